// File: rtl/fm0_pkg.sv
// Shared types and constants for the FM0 bit decoder: FSM states, CRC-16/CCITT
// constants and the bank-to-half-symbol-length mapping.
package fm0_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    DONE
  } fm0_state_e;

  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
  // Register value after data followed by its complemented CRC.
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

  function automatic int unsigned half_len(input int unsigned bank,
                                           input int unsigned half_base,
                                           input int unsigned half_step);
    return half_base + bank * half_step;
  endfunction

endpackage

// File: rtl/fm0_half_integrator.sv
// Counts strobed samples of one FM0 half-symbol and majority-votes its level;
// done pulses combinationally with the sample that completes the half.
module fm0_half_integrator #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          smp_vld,
  input  logic          smp_dat,
  input  logic [CW-1:0] half_len,
  output logic          done,
  output logic          level
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [CW-1:0] cnt_inc, ones_inc;

  always_comb begin
    cnt_inc  = cnt_q + CW'(1);
    ones_inc = ones_q + CW'(smp_dat);
    done     = smp_vld && (cnt_inc == half_len);
    // 2*ones >= H, so an exact tie votes high.
    level    = ({ones_inc, 1'b0} >= {1'b0, half_len});
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    if (clear) begin
      cnt_d  = '0;
      ones_d = '0;
    end else if (smp_vld) begin
      if (done) begin
        cnt_d  = '0;
        ones_d = '0;
      end else begin
        cnt_d  = cnt_inc;
        ones_d = ones_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      ones_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/fm0_bit_decoder.sv
// FM0 bit decoder framed by preamble/postamble. in_vld qualifies in_dat for one
// cycle with no backpressure. Optional CRC-16 check under FM0_CRC16_CHECK_EN.
module fm0_bit_decoder
  import fm0_pkg::*;
#(
  parameter int unsigned BANKS     = 4,
  parameter int unsigned HALF_BASE = 4,
  parameter int unsigned HALF_STEP = 1,
  parameter int unsigned MAX_BITS  = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_dat,
  input  logic                         in_vld,
  input  logic [$clog2(BANKS)-1:0]     frequency_bank,
  input  logic                         preamble_detected,
  input  logic                         postamble_detected,
  output logic                         bit_dat,
  output logic                         bit_vld,
  output logic [$clog2(MAX_BITS+1)-1:0] bit_count,
  output logic                         frame_end,
  output logic                         frame_err,
  output logic                         crc_ok
);

  localparam int unsigned H_MAX = HALF_BASE + (BANKS - 1) * HALF_STEP;
  localparam int unsigned HW    = $clog2(H_MAX + 1);
  localparam int unsigned CW    = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] BITS_CAP = CW'(MAX_BITS);

  fm0_state_e    state_q, state_d;
  logic [HW-1:0] half_len_q, half_len_d;
  logic [CW-1:0] bit_count_q, bit_count_d, bit_count_inc;
  logic          err_q, err_d;
  logic          first_lvl_q, first_lvl_d;
  logic          prev_lvl_q, prev_lvl_d;
  logic          have_prev_q, have_prev_d;
  logic          bit_dat_q, bit_dat_d;
  logic          bit_vld_q, bit_vld_d;

  logic start, in_frame, smp_vld, half_done, half_level;

  assign start    = (state_q == IDLE) && preamble_detected;
  assign in_frame = (state_q == FIRST) || (state_q == SECOND);
  // Samples coincident with a frame marker never reach the integrator.
  assign smp_vld  = in_frame && in_vld && !preamble_detected && !postamble_detected;

  fm0_half_integrator #(.CW(HW)) u_half (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .smp_vld  (smp_vld),
    .smp_dat  (in_dat),
    .half_len (half_len_q),
    .done     (half_done),
    .level    (half_level)
  );

  always_comb begin
    state_d       = state_q;
    half_len_d    = half_len_q;
    bit_count_d   = bit_count_q;
    bit_count_inc = bit_count_q + CW'(1);
    err_d         = err_q;
    first_lvl_d   = first_lvl_q;
    prev_lvl_d    = prev_lvl_q;
    have_prev_d   = have_prev_q;
    bit_dat_d     = bit_dat_q;
    bit_vld_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (preamble_detected) begin
          half_len_d  = HW'(half_len(32'(frequency_bank), HALF_BASE, HALF_STEP));
          bit_count_d = '0;
          err_d       = 1'b0;
          have_prev_d = 1'b0;
          state_d     = FIRST;
        end
      end
      FIRST, SECOND: begin
        if (preamble_detected) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (postamble_detected) begin
          state_d = DONE;
        end else if (half_done) begin
          if (state_q == FIRST) begin
            first_lvl_d = half_level;
            // FM0 requires an inversion at every symbol boundary.
            if (have_prev_q && (half_level == prev_lvl_q)) err_d = 1'b1;
            state_d = SECOND;
          end else begin
            bit_dat_d   = (first_lvl_q == half_level);
            bit_vld_d   = 1'b1;
            prev_lvl_d  = half_level;
            have_prev_d = 1'b1;
            bit_count_d = bit_count_inc;
            if (bit_count_inc == BITS_CAP) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = FIRST;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      half_len_q  <= HW'(HALF_BASE);
      bit_count_q <= '0;
      err_q       <= 1'b0;
      first_lvl_q <= 1'b0;
      prev_lvl_q  <= 1'b0;
      have_prev_q <= 1'b0;
      bit_dat_q   <= 1'b0;
      bit_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_len_q  <= half_len_d;
      bit_count_q <= bit_count_d;
      err_q       <= err_d;
      first_lvl_q <= first_lvl_d;
      prev_lvl_q  <= prev_lvl_d;
      have_prev_q <= have_prev_d;
      bit_dat_q   <= bit_dat_d;
      bit_vld_q   <= bit_vld_d;
    end
  end

  assign bit_dat   = bit_dat_q;
  assign bit_vld   = bit_vld_q;
  assign bit_count = bit_count_q;
  assign frame_end = (state_q == DONE);
  assign frame_err = frame_end && err_q;

`ifdef FM0_CRC16_CHECK_EN
  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (start) begin
      crc_d = CRC_PRESET;
    end else if (bit_vld_d) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_dat_d) ? CRC_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_PRESET;
    else     crc_q <= crc_d;
  end

  assign crc_ok = frame_end && !err_q && (crc_q == CRC_RESIDUE);
`else
  assign crc_ok = 1'b0;
`endif

endmodule

// File: doc/fm0_bit_decoder.md
# fm0_bit_decoder

Decodes the 1-bit sample stream released by the preamble detector (out_dat/out_vld) into FM0 data bits, using the detector's frequency_bank to set the half-symbol length. It frames each tag reply between preamble_detected and postamble_detected, majority-votes each half-symbol and flags FM0 boundary violations. It presents decoded bits and a frame summary to the downstream packet parser.

## Interface
- BANKS, 4: number of correlator frequency banks; must match the detector.
- HALF_BASE, 4: samples per FM0 half-symbol for bank 0.
- HALF_STEP, 1: extra samples per half-symbol per bank index; H = HALF_BASE + bank*HALF_STEP.
- MAX_BITS, 128: frame length cap in decoded bits.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_dat  in  1  sample from detector out_dat.
- in_vld  in  1  sample strobe from detector out_vld.
- frequency_bank  in  $clog2(BANKS)  bank chosen by the detector; sampled only on preamble_detected.
- preamble_detected  in  1  one-cycle frame start.
- postamble_detected  in  1  one-cycle frame end.
- bit_dat  out  1  decoded bit.
- bit_vld  out  1  one-cycle strobe for bit_dat.
- bit_count  out  $clog2(MAX_BITS+1)  bits emitted in the current/last frame.
- frame_end  out  1  one-cycle end-of-frame strobe.
- frame_err  out  1  qualified by frame_end: boundary violation, abort or overflow.
- crc_ok  out  1  qualified by frame_end (see Configuration).

## Operation
- States: IDLE, FIRST (collecting first half), SECOND (collecting second half), DONE (one cycle, drives frame_end).
- IDLE: in_vld ignored. On preamble_detected, latch H from frequency_bank, clear the sample counter, ones counter, bit_count, error and CRC, then go to FIRST.
- FIRST/SECOND: each in_vld increments the sample counter and adds in_dat to the ones counter. After the H-th sample the half level is 1 if 2*ones >= H (ties resolve to 1). The counters then clear and the state alternates.
- Bit decision at the end of SECOND: bit_dat = (first level == second level). Equal levels decode as data-1; a mid-symbol inversion decodes as data-0.
- Boundary check: from the second symbol onward, if the first-half level equals the previous symbol's second-half level, set the sticky error. The bit is still emitted.
- postamble_detected in FIRST/SECOND: discard any partial symbol and go to DONE.
- When bit_count reaches MAX_BITS: set error (overflow) and go to DONE.
- preamble_detected in FIRST/SECOND: abort. Go to DONE with frame_err=1. The new frame is not started; the detector issues another preamble after IDLE.
- DONE: frame_end=1 and frame_err=sticky error; the next state is IDLE. bit_count holds its value until the next preamble_detected.
- Samples arriving in DONE or IDLE are dropped. This includes the trailing out_vld sample the detector emits one cycle after postamble_detected.

## Timing
- Reset: state IDLE, and bit_dat, bit_vld, bit_count, frame_end, frame_err and crc_ok all 0.
- bit_vld asserts the cycle after the clock edge that registers the 2H-th sample of a symbol.
- frame_end asserts the cycle after postamble_detected, the abort, or the edge that emits the MAX_BITS-th bit.
- in_vld coincident with postamble_detected: the sample is discarded.
- in_vld may have gaps of any length; only strobed samples count.
- Reset mid-frame: return to IDLE with no frame_end.

## Configuration
- FM0_CRC16_CHECK_EN defined:
  - Run CRC-16/CCITT (poly 0x1021, preset 0xFFFF) serially over every emitted bit.
  - At frame_end, crc_ok=1 iff the register equals residue 0x1D0F and frame_err=0.
- Undefined: no CRC logic is built and crc_ok is tied to 0.

## Structure
- Package fm0_pkg holds:
  - the state enum;
  - CRC_POLY and CRC_PRESET;
  - CRC_RESIDUE;
  - the function half_len(bank, HALF_BASE, HALF_STEP).
- Sub-module fm0_half_integrator: sample counter, ones counter and majority output with a done strobe. It is instantiated once and reused for both halves.
- CRC stays inline, under the macro.

## Test plan
- Bank 0 (H=4), clean FM0 "1,0,1,1", in_vld every cycle, then postamble: 4 bit_vld pulses with 1,0,1,1; frame_end with frame_err=0 and bit_count=4.
- Bank 2 (H=6), half-symbols with one corrupt sample each: same bits decoded; a 3/6 tie resolves to 1.
- Missing boundary inversion between symbols 2 and 3: all bits still emitted; frame_err=1 at frame_end.
- MAX_BITS=8, 10 symbols sent: exactly 8 bit_vld pulses, then frame_end with frame_err=1. Later samples are ignored.
- Postamble mid-symbol, plus a trailing in_vld one cycle later: no extra bit_vld; frame_end follows postamble by 1 cycle.
- With FM0_CRC16_CHECK_EN, a 16-bit payload plus correct CRC: crc_ok=1. With 1 payload bit flipped: crc_ok=0.
